pe_col_drain: RTL and testbench

Output drain unit at the bottom of one systolic-array column. It captures a burst of 32-bit accumulator results leaving the last PE's `o_o` port. Each result is converted from accumulator fixed point (2·FRA_BW fraction bits) to operand fixed point (FRA_BW fraction bits, saturated to INT_BW integer bits). Results are buffered in a small FIFO and handed to the writeback path over a valid/ready interface. One instance sits under each column.

---
 rtl/pe_col_drain.sv | 146 ++++++++++++++
 tb/tb_pe_col_drain.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_col_drain.sv
// pe_col_drain: drain unit under one systolic column. It converts accumulator results to
// operand fixed point, buffers one burst in a FIFO and hands it out on valid/ready.
// Define RAVEN_DRAIN_RND_EN to round half up before the shift; the default is floor truncation.
module pe_col_drain #(
  parameter int INT_BW = 5,
  parameter int FRA_BW = 6,
  parameter int MUL_BW = 16,
  parameter int ACC_BW = 32,
  parameter int DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [$clog2(DEPTH+1)-1:0]  len_i,
  input  logic signed [ACC_BW-1:0]    o_i,
  input  logic                        o_vld_i,
  output logic signed [MUL_BW-1:0]    dat_o,
  output logic                        vld_o,
  input  logic                        rdy_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        sat_o
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int XW = ACC_BW + 1;
  localparam logic [LW-1:0]        DEPTH_L = LW'(DEPTH);
  localparam logic signed [XW-1:0] SAT_MAX = XW'((64'sd1 <<< (INT_BW + FRA_BW)) - 64'sd1);
  localparam logic signed [XW-1:0] SAT_MIN = ~SAT_MAX;
`ifdef RAVEN_DRAIN_RND_EN
  localparam logic signed [XW-1:0] RND     = XW'(64'sd1 <<< (FRA_BW - 1));
`endif

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          sat_q, sat_d;
  logic          done_q, done_d;

  logic [MUL_BW-1:0] mem_q [DEPTH];
  logic [PW:0]       wr_ptr_q, rd_ptr_q;
  logic              empty, full, push_req, push, pop, last_pop;

  logic signed [XW-1:0] x_ext, x_shf;
  logic [MUL_BW-1:0]    conv_val;
  logic                 conv_sat;

  // One extra bit of headroom so the rounding add can never wrap before the clamp.
  always_comb begin
    x_ext = {o_i[ACC_BW-1], o_i};
`ifdef RAVEN_DRAIN_RND_EN
    x_ext = x_ext + RND;
`endif
    x_shf    = x_ext >>> FRA_BW;
    conv_sat = 1'b1;
    if (x_shf > SAT_MAX) begin
      conv_val = MUL_BW'(SAT_MAX);
    end else if (x_shf < SAT_MIN) begin
      conv_val = MUL_BW'(SAT_MIN);
    end else begin
      conv_val = MUL_BW'(x_shf);
      conv_sat = 1'b0;
    end
  end

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push_req = (state_q == CAPTURE) && o_vld_i;
  assign push     = push_req && !full;
  assign pop      = !empty && rdy_i;
  assign last_pop = pop && ((rd_ptr_q + (PW+1)'(1)) == wr_ptr_q);

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  // NOTE: the storage array has no reset; dat_o is masked while empty, so stale words never leak.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= conv_val;
  end

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d = (len_i > DEPTH_L) ? DEPTH_L : len_i;
          cnt_d = '0;
          sat_d = 1'b0;
          if (len_d == '0) done_d = 1'b1;
          else             state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (o_vld_i) begin
          cnt_d = cnt_q + LW'(1);
          if (push && conv_sat) sat_d = 1'b1;
          if (cnt_d == len_q)   state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
      if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

  assign dat_o  = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
  assign vld_o  = !empty;
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign sat_o  = sat_q;

  // A burst never exceeds DEPTH and starts on an empty FIFO, so a push must never see it full.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_req && full));

endmodule

// File: tb/tb_pe_col_drain.sv
// tb_pe_col_drain: directed scenarios for pe_col_drain at default parameters.
// Observed word is {vld_o, busy_o, done_o, sat_o, dat_o}.
module tb_pe_col_drain;

  logic               clk     = 1'b0;
  logic               rst_n   = 1'b0;
  logic               start_i = 1'b0;
  logic [3:0]         len_i   = '0;
  logic signed [31:0] o_i     = '0;
  logic               o_vld_i = 1'b0;
  logic               rdy_i   = 1'b0;
  logic signed [15:0] dat_o;
  logic               vld_o, busy_o, done_o, sat_o;

  logic [19:0] obs, exp_v;
  int total = 0;
  int bad   = 0;

`ifdef RAVEN_DRAIN_RND_EN
  localparam logic [15:0] RND_A = 16'h0000;
  localparam logic [15:0] RND_B = 16'h0001;
`else
  localparam logic [15:0] RND_A = 16'hFFFF;
  localparam logic [15:0] RND_B = 16'h0000;
`endif

  always #5 clk = ~clk;

  pe_col_drain dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .len_i   (len_i),
    .o_i     (o_i),
    .o_vld_i (o_vld_i),
    .dat_o   (dat_o),
    .vld_o   (vld_o),
    .rdy_i   (rdy_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sat_o   (sat_o)
  );

  assign obs = {vld_o, busy_o, done_o, sat_o, dat_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    exp_v = {4'b0000, 16'h0000};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL reset_hold got=%h exp=%h", obs, exp_v); end
    #9 rst_n = 1'b1;
    tick();
    total++; if (obs !== exp_v) begin bad++; $display("FAIL reset_release got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_unity();
    start_i = 1'b1; len_i = 4'd1;
    tick();
    exp_v = {4'b0100, 16'h0000};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL unity_start got=%h exp=%h", obs, exp_v); end
    start_i = 1'b0; o_i = 32'h0000_1000; o_vld_i = 1'b1;
    tick();
    exp_v = {4'b1100, 16'h0040};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL unity_data got=%h exp=%h", obs, exp_v); end
    o_vld_i = 1'b0; rdy_i = 1'b1;
    tick();
    exp_v = {4'b0010, 16'h0000};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL unity_done got=%h exp=%h", obs, exp_v); end
    rdy_i = 1'b0;
    tick();
    exp_v = {4'b0000, 16'h0000};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL unity_idle got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_saturation();
    start_i = 1'b1; len_i = 4'd2;
    tick();
    exp_v = {4'b0100, 16'h0000};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL sat_start got=%h exp=%h", obs, exp_v); end
    start_i = 1'b0; o_i = 32'h0010_0000; o_vld_i = 1'b1;
    tick();
    exp_v = {4'b1101, 16'h07FF};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL sat_pos got=%h exp=%h", obs, exp_v); end
    o_i = 32'hFFF0_0000;
    tick();
    total++; if (obs !== exp_v) begin bad++; $display("FAIL sat_hold got=%h exp=%h", obs, exp_v); end
    o_vld_i = 1'b0; rdy_i = 1'b1;
    tick();
    exp_v = {4'b1101, 16'hF800};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL sat_neg got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {4'b0011, 16'h0000};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL sat_done got=%h exp=%h", obs, exp_v); end
    // Zero-length burst: only a done pulse, and the sticky flag is cleared.
    rdy_i = 1'b0; start_i = 1'b1; len_i = 4'd0;
    tick();
    exp_v = {4'b0010, 16'h0000};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL len0_done got=%h exp=%h", obs, exp_v); end
    start_i = 1'b0;
    tick();
    exp_v = {4'b0000, 16'h0000};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL len0_idle got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_rounding();
    start_i = 1'b1; len_i = 4'd2;
    tick();
    exp_v = {4'b0100, 16'h0000};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL rnd_start got=%h exp=%h", obs, exp_v); end
    start_i = 1'b0; o_i = 32'hFFFF_FFFF; o_vld_i = 1'b1; rdy_i = 1'b1;
    tick();
    exp_v = {4'b1100, RND_A};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL rnd_neg1 got=%h exp=%h", obs, exp_v); end
    o_i = 32'h0000_0020;
    tick();
    exp_v = {4'b1100, RND_B};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL rnd_half got=%h exp=%h", obs, exp_v); end
    o_vld_i = 1'b0;
    tick();
    exp_v = {4'b0010, 16'h0000};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL rnd_done got=%h exp=%h", obs, exp_v); end
    rdy_i = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    start_i = 1'b1; len_i = 4'd8;
    tick();
    start_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      o_i = 32'(i) <<< 12; o_vld_i = 1'b1;
      tick();
      exp_v = {4'b1100, 16'h0040};
      total++; if (obs !== exp_v) begin bad++; $display("FAIL bp_fill%0d got=%h exp=%h", i, obs, exp_v); end
    end
    o_vld_i = 1'b0; rdy_i = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_v = {4'b1100, 16'((k + 1) * 64)};
      total++; if (obs !== exp_v) begin bad++; $display("FAIL bp_pop%0d got=%h exp=%h", k, obs, exp_v); end
    end
    tick();
    exp_v = {4'b0010, 16'h0000};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL bp_done got=%h exp=%h", obs, exp_v); end
  endtask

  // Starts in the done cycle of the previous burst; len above DEPTH and start while busy.
  task automatic test_len_clamp();
    int  n    = 0;
    bit  seen = 1'b0;
    start_i = 1'b1; len_i = 4'd15; rdy_i = 1'b0;
    tick();
    exp_v = {4'b0100, 16'h0000};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL clamp_start got=%h exp=%h", obs, exp_v); end
    len_i = 4'd3;
    for (int i = 0; i < 10; i++) begin
      o_i = 32'(i + 1) <<< 6; o_vld_i = 1'b1;
      tick();
    end
    o_vld_i = 1'b0; start_i = 1'b0; rdy_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (done_o) begin seen = 1'b1; break; end
      if (vld_o) begin
        total++;
        if (dat_o !== 16'(n + 1)) begin
          bad++; $display("FAIL clamp_order%0d got=%h exp=%h", n, dat_o, 16'(n + 1));
        end
        n++;
      end
      tick();
    end
    total++; if (!seen || n != 8) begin bad++; $display("FAIL clamp_count got=%0d done=%0d exp=8 done=1", n, seen); end
    tick();
    exp_v = {4'b0000, 16'h0000};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL clamp_idle got=%h exp=%h", obs, exp_v); end
    rdy_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1; len_i = 4'd8;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      o_i = 32'(i + 1) <<< 12; o_vld_i = 1'b1;
      tick();
    end
    o_vld_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_v = {4'b0000, 16'h0000};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL rstmid_async got=%h exp=%h", obs, exp_v); end
    #2 rst_n = 1'b1;
    tick();
    total++; if (obs !== exp_v) begin bad++; $display("FAIL rstmid_release got=%h exp=%h", obs, exp_v); end
    start_i = 1'b1; len_i = 4'd1;
    tick();
    exp_v = {4'b0100, 16'h0000};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL rstmid_start got=%h exp=%h", obs, exp_v); end
    start_i = 1'b0; o_i = 32'h0000_1000; o_vld_i = 1'b1;
    tick();
    exp_v = {4'b1100, 16'h0040};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL rstmid_data got=%h exp=%h", obs, exp_v); end
    o_vld_i = 1'b0; rdy_i = 1'b1;
    tick();
    exp_v = {4'b0010, 16'h0000};
    total++; if (obs !== exp_v) begin bad++; $display("FAIL rstmid_done got=%h exp=%h", obs, exp_v); end
    rdy_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unity();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_len_clamp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
